jk_bank_arbiter: RTL
====================

# jk_bank_arbiter

Arbiter and sequencer that shares one external bank of WIDTH JK flip-flops between two requesters. It accepts hold/reset/set/toggle commands with a per-bit mask and grants them round-robin. It drives the bank's J/K inputs for exactly one clock and, when configured, reads Q back to confirm the update. It sits directly in front of the JK flip-flop bank; no other agent drives J/K.

## Interface
- WIDTH, default 4, number of JK flip-flops in the bank (1..32)

- CLK  in  1  rising-edge clock, shared with the JK bank
- RST_N  in  1  asynchronous active-low reset
- REQ  in  2  request per requester (bit 0 = requester 0)
- OP0  in  2  requester 0 opcode
- MASK0  in  WIDTH  requester 0 bit select
- OP1  in  2  requester 1 opcode
- MASK1  in  WIDTH  requester 1 bit select
- Q  in  WIDTH  current outputs of the JK bank
- J  out  WIDTH  J inputs to the bank
- K  out  WIDTH  K inputs to the bank
- GNT  out  2  one-hot grant, one-cycle pulse
- DONE  out  2  one-hot completion, one-cycle pulse to the owner
- ERR  out  1  readback mismatch, valid only while DONE is nonzero
- BUSY  out  1  high whenever state is not IDLE

## Operation
- Opcodes, applied only to bits where MASK=1:
  - 00 hold: J=0, K=0.
  - 01 reset: J=0, K=1.
  - 10 set: J=1, K=0.
  - 11 toggle: J=1, K=1.
- Unmasked bits always get J=K=0.
- States are IDLE, DRIVE, CHECK and DONE. All outputs are registered.
- IDLE:
  - If any REQ bit is high, select the owner.
  - Latch the owner's OP and MASK.
  - Snapshot Q and compute EXP per bit: hold and unmasked bits keep the snapshot; reset gives 0; set gives 1; toggle gives ~snapshot.
  - Load J/K, pulse GNT[owner], then go to DRIVE.
- DRIVE: J/K are held for this one cycle. Then J/K go to 0, GNT goes to 0, and the state goes to CHECK.
- CHECK: compare Q with EXP. Set ERR to 1 if any bit differs. Assert DONE[owner]. Go to DONE.
- DONE: DONE and ERR are held for this one cycle. Then clear DONE and ERR, move the priority pointer to the other requester, and go to IDLE.
- Arbitration:
  - A single request wins immediately.
  - When both REQ bits are high, the requester named by the pointer wins.
  - The pointer resets to requester 0. It updates only on completion.
- Requester rules:
  - REQ must stay high until GNT.
  - OP and MASK are sampled only on the granting edge.
  - A REQ still high in IDLE after DONE is treated as a new command.
  - The loser of a tie keeps REQ high and is served next.

## Timing
- REQ is sampled at edge 0. GNT, J and K are valid in cycle 1. The bank samples J/K at edge 1.
- Q is compared at edge 2. DONE and ERR are valid in cycle 3. IDLE is reached in cycle 4.
- Throughput is one command per 4 cycles; a new REQ can be sampled at edge 4.
- Reset values: J=0, K=0, GNT=0, DONE=0, ERR=0, BUSY=0, state IDLE, pointer 0.
- Reset mid-command: all of the above are forced immediately and asynchronously. The command is discarded with no DONE pulse.
- MASK=0: the full sequence still runs with J=K=0, and ERR=0 provided Q is stable.
- Q changing for any reason other than the granted command, between the snapshot and the compare, produces ERR=1.
- REQ arriving while BUSY is ignored until IDLE.

## Configuration
- Macro JK_BANK_CHECK_EN.
- Defined: the CHECK state exists and ERR reports the readback compare. Latency is 4 cycles per command as above.
- Undefined: CHECK and the EXP logic are removed and DRIVE goes directly to DONE.
  - DONE is valid in cycle 2, and throughput is one command per 3 cycles.
  - ERR is tied to 0.

## Test plan
- Reset release with WIDTH=4 and Q=0000, then REQ=01, OP0=10, MASK0=1010:
  - GNT=01 and J=1010, K=0000 in cycle 1.
  - Q=1010 after edge 1.
  - DONE=01 and ERR=0 in cycle 3.
- Toggle with Q=1010, REQ=10, OP1=11, MASK1=1111: J=K=1111 for one cycle, Q becomes 0101, DONE=10, ERR=0.
- Simultaneous REQ=11 after reset, both held:
  - Requester 0 is granted first, then requester 1.
  - Then requester 0 again; GNT alternates 01, 10, 01 at 4-cycle spacing.
- Readback fault: during a set on MASK=0001 the bench forces Q[0]=0 after edge 1 -> DONE with ERR=1.
- Reset mid-command: assert RST_N=0 during DRIVE -> J, K, GNT, DONE, ERR and BUSY all go to 0 at once; no DONE pulse follows; the next request is granted from IDLE with the pointer at 0.
- MASK0=0000 with OP0=11 -> J=K=0000 throughout, Q unchanged, DONE=01, ERR=0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter/sequencer for a shared external JK flip-flop bank
//
// Purpose:
//    Two requesters share one bank of WIDTH JK flip-flops. A granted command
//    (hold/reset/set/toggle under a per-bit mask) is driven onto J/K for one
//    clock. With JK_BANK_CHECK_EN defined, the bank Q is read back one cycle
//    later and compared against the expected value.
//
// Configuration macro:
//    JK_BANK_CHECK_EN  defined   : IDLE -> DRIVE -> CHECK -> DONE, ERR reports readback
//                      undefined : IDLE -> DRIVE -> DONE, ERR tied to 0
//
// Ports:
//    clk        in   rising-edge clock, shared with the JK bank
//    rst_n      in   asynchronous active-low reset
//    req[1:0]   in   request per requester (bit 0 = requester 0)
//    op0, op1   in   opcode per requester: 00 hold, 01 reset, 10 set, 11 toggle
//    mask0/1    in   per-bit select per requester
//    q          in   current outputs of the JK bank
//    j, k       out  JK bank inputs (registered)
//    gnt[1:0]   out  one-hot grant pulse
//    done[1:0]  out  one-hot completion pulse to the owner
//    err        out  readback mismatch, valid only while done is nonzero
//    busy       out  high whenever the sequencer is not idle

module jk_bank_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] mask0,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] mask1,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             err,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   // Winner of the current request pattern; the pointer only matters on a tie.
   logic             win_owner;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_mask;
   logic [WIDTH-1:0] sel_j;
   logic [WIDTH-1:0] sel_k;

   always_comb begin
      win_owner = (req == 2'b10) || ((req == 2'b11) && ptr_q);
      sel_op    = win_owner ? op1 : op0;
      sel_mask  = win_owner ? mask1 : mask0;
      // Opcode bit 1 is J, bit 0 is K for every masked bit.
      sel_j     = sel_mask & {WIDTH{sel_op[1]}};
      sel_k     = sel_mask & {WIDTH{sel_op[0]}};
   end

`ifdef JK_BANK_CHECK_EN
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] sel_exp;

   // Expected bank value after the drive is the JK characteristic equation
   // applied to the snapshot; unmasked bits have J=K=0 and so keep their value.
   assign sel_exp = (sel_j & ~q) | (~sel_k & q);
`else
   logic unused_q;
   assign unused_q = ^q;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (|req) state_d = S_DRIVE;
         end
         S_DRIVE: begin
`ifdef JK_BANK_CHECK_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
         end
         S_CHECK: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values; every output is taken from a flop.
   always_comb begin
      owner_d = owner_q;
      ptr_d   = ptr_q;
      j_d     = '0;
      k_d     = '0;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      err_d   = 1'b0;
`ifdef JK_BANK_CHECK_EN
      exp_d   = exp_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d = win_owner;
               j_d     = sel_j;
               k_d     = sel_k;
               gnt_d   = {win_owner, ~win_owner};
`ifdef JK_BANK_CHECK_EN
               exp_d   = sel_exp;
`endif
            end
         end
         S_DRIVE: begin
`ifndef JK_BANK_CHECK_EN
            done_d = {owner_q, ~owner_q};
`endif
         end
         S_CHECK: begin
`ifdef JK_BANK_CHECK_EN
            done_d = {owner_q, ~owner_q};
            err_d  = |(q ^ exp_q);
`endif
         end
         S_DONE: begin
            // Give the other requester priority on the next tie.
            ptr_d = ~owner_q;
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         j_q     <= '0;
         k_q     <= '0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef JK_BANK_CHECK_EN
         exp_q   <= '0;
`endif
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         j_q     <= j_d;
         k_q     <= k_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
`ifdef JK_BANK_CHECK_EN
         exp_q   <= exp_d;
`endif
      end
   end

   assign j    = j_q;
   assign k    = k_q;
   assign gnt  = gnt_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = busy_q;

endmodule
